// File: rtl/elvds_rx_monitor_if.sv
// Status bundle for the emulated-LVDS receive monitor: pair in, link status out.
// Latency: none; plain wires between the transmitter side and the monitor.
// Backpressure: none; status outputs are strobes and levels, there is no ready.
interface elvds_rx_monitor_if #(
  parameter int CNT_W = 26
);
  logic             elvds_p;
  logic             elvds_n;
  logic             rx_level;
  logic             rise_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             link_ok;
  logic [15:0]      edge_cnt;

  // Transmitter / environment side: drives the pair, observes status
  modport master (
    output elvds_p, elvds_n,
    input  rx_level, rise_pulse, period, period_valid, link_ok, edge_cnt
  );

  // Monitor side: receives the pair, produces status
  modport slave (
    input  elvds_p, elvds_n,
    output rx_level, rise_pulse, period, period_valid, link_ok, edge_cnt
  );
endinterface

// File: rtl/elvds_rx_monitor.sv
// Receive monitor for the emulated-LVDS link: sync, glitch filter, rise-to-rise period and lock qualification.
// Latency: pad step to rise_pulse is SYNC_STAGES+FILTER_LEN+1 cycles; period/period_valid/link_ok one cycle after rise_pulse.
// Backpressure: none; outputs are free-running status levels and one-cycle strobes.
module elvds_rx_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int CNT_W       = 26,
  parameter int MIN_PERIOD  = 1024,
  parameter int TIMEOUT     = 50000000,
  parameter int LOCK_EDGES  = 3
) (
  input logic              clk,
  input logic              rst_n,
  elvds_rx_monitor_if.slave lnk
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int GW = $clog2(LOCK_EDGES + 1);

  localparam logic [FW-1:0]    FLEN_M1  = FW'(FILTER_LEN - 1);
  localparam logic [GW-1:0]    GLOCK    = GW'(LOCK_EDGES);
  localparam logic [GW-1:0]    GLOCK_M1 = GW'(LOCK_EDGES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_LOS  = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  // Behavioural stand-in for ELVDS_IBUF: output high when the true leg is above the complement leg
  logic ibuf_o;
  assign ibuf_o = lnk.elvds_p & ~lnk.elvds_n;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
  logic                   rx_level_q, rx_level_d;
  logic                   lvl_prev_q, lvl_prev_d;
  logic                   rise_q, rise_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       meas;
  logic                   meas_ok;
  logic                   timeout_hit;
  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          good_q, good_d;
  logic [15:0]            edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   pv_q, pv_d;
  logic                   link_ok_q, link_ok_d;

  // Shift the buffered pad level through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ibuf_o};
  end

  // Glitch filter: flip the level only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    rx_level_d = rx_level_q;
    flt_cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != rx_level_q) begin
      if (flt_cnt_q == FLEN_M1) begin
        rx_level_d = ~rx_level_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  // Registered rising-edge strobe, one cycle after the filtered level goes high
  always_comb begin
    lvl_prev_d = rx_level_q;
    rise_d     = rx_level_q & ~lvl_prev_q;
  end

  // Gap counter: meas is the rise-to-rise distance, the counter restarts on every rise
  always_comb begin
    meas        = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    meas_ok     = (meas >= MIN_P) && (meas <= TMO);
    timeout_hit = (cnt_q == TMO_M1);
    cnt_d       = rise_q ? '0 : meas;
  end

  // Link qualification FSM; a rise always wins over a coincident timeout
  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    edge_cnt_d = edge_cnt_q;
    period_d   = period_q;
    pv_d       = 1'b0;
    case (state_q)
      ST_LOS: begin
        if (rise_q) begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
      end
      ST_ACQ: begin
        if (rise_q) begin
          pv_d     = 1'b1;
          period_d = meas;
          if (meas_ok) begin
            if (good_q == GLOCK_M1) begin
              state_d = ST_LOCK;
              good_d  = GLOCK;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout_hit) begin
          state_d    = ST_LOS;
          good_d     = '0;
          edge_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (rise_q) begin
          pv_d     = 1'b1;
          period_d = meas;
          if (meas_ok) begin
            edge_cnt_d = edge_cnt_q + 16'd1;
          end else begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end else if (timeout_hit) begin
          state_d    = ST_LOS;
          good_d     = '0;
          edge_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_LOS;
        good_d     = '0;
        edge_cnt_d = '0;
      end
    endcase
    link_ok_d = (state_d == ST_LOCK);
  end

  // All state registers; reset forces the idle LOS state immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      flt_cnt_q  <= '0;
      rx_level_q <= 1'b0;
      lvl_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      cnt_q      <= '0;
      state_q    <= ST_LOS;
      good_q     <= '0;
      edge_cnt_q <= '0;
      period_q   <= '0;
      pv_q       <= 1'b0;
      link_ok_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      flt_cnt_q  <= flt_cnt_d;
      rx_level_q <= rx_level_d;
      lvl_prev_q <= lvl_prev_d;
      rise_q     <= rise_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      good_q     <= good_d;
      edge_cnt_q <= edge_cnt_d;
      period_q   <= period_d;
      pv_q       <= pv_d;
      link_ok_q  <= link_ok_d;
    end
  end

  assign lnk.rx_level     = rx_level_q;
  assign lnk.rise_pulse   = rise_q;
  assign lnk.period       = period_q;
  assign lnk.period_valid = pv_q;
  assign lnk.link_ok      = link_ok_q;
  assign lnk.edge_cnt     = edge_cnt_q;

endmodule

// File: tb/tb_elvds_rx_monitor.sv
// Bench for the emulated-LVDS receive monitor: directed link scenarios then random rise-to-rise gaps.
// Expected rise timing, period, lock and edge count come from a gap-list model of the link rules.
// Inputs change on the falling clock edge; outputs are sampled 1 time unit after the rising edge.
module tb_elvds_rx_monitor;

  localparam int CNT_W = 26;
  localparam int MIN_P = 10;
  localparam int TMO   = 100;
  localparam int LOCK  = 3;
  localparam int LAT   = 7;

  typedef struct {
    int cyc;
    bit pv;
    int period;
    bit link;
    int edg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc       = 0;
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   pv_total  = 0;

  exp_t exp_q[$];
  exp_t cur;
  bit   armed = 1'b0;

  bit m_has_ref = 1'b0;
  int m_last    = 0;
  int m_run     = 0;
  int m_edge    = 0;

  elvds_rx_monitor_if #(.CNT_W(CNT_W)) lnk();

  elvds_rx_monitor #(
    .SYNC_STAGES(2),
    .FILTER_LEN (4),
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_P),
    .TIMEOUT    (TMO),
    .LOCK_EDGES (LOCK)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lnk  (lnk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_asserts++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic set_pad(input logic v);
    lnk.elvds_p = v;
    lnk.elvds_n = ~v;
  endtask

  task automatic model_reset();
    m_has_ref = 1'b0;
    m_last    = 0;
    m_run     = 0;
    m_edge    = 0;
    exp_q.delete();
  endtask

  // Gap-list model: a pad rise driven after clock edge k must strobe at edge k+LAT
  task automatic model_rise(input int k);
    exp_t e;
    int   gap;
    gap   = k - m_last;
    e.cyc = k + LAT;
    if (!m_has_ref || gap > TMO) begin
      m_has_ref = 1'b1;
      m_run     = 0;
      m_edge    = 0;
      e.pv      = 1'b0;
      e.period  = 0;
      e.link    = 1'b0;
      e.edg     = 0;
    end else begin
      e.pv     = 1'b1;
      e.period = gap;
      if (gap >= MIN_P && gap <= TMO) begin
        m_run++;
        if (m_run > LOCK) m_edge = (m_edge + 1) % 65536;
      end else begin
        m_run = 0;
      end
      e.link = (m_run >= LOCK);
      e.edg  = m_edge;
    end
    m_last = k;
    exp_q.push_back(e);
  endtask

  task automatic pad_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      set_pad(1'b1);
      if (i == 0) model_rise(cyc);
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      set_pad(1'b0);
    end
  endtask

  task automatic idle_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_pad(1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rx_level"},     32'(lnk.rx_level),     32'd0);
    chk({tag, "_rise_pulse"},   32'(lnk.rise_pulse),   32'd0);
    chk({tag, "_period"},       32'(lnk.period),       32'd0);
    chk({tag, "_period_valid"}, 32'(lnk.period_valid), 32'd0);
    chk({tag, "_link_ok"},      32'(lnk.link_ok),      32'd0);
    chk({tag, "_edge_cnt"},     32'(lnk.edge_cnt),     32'd0);
  endtask

  // Scoreboard: every rise_pulse must match the oldest expected rise; outputs checked one cycle later
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      armed = 1'b0;
    end else begin
      if (lnk.period_valid) pv_total++;
      if (armed) begin
        chk("sb_pv",         32'(lnk.period_valid), 32'(cur.pv));
        if (cur.pv) chk("sb_period", 32'(lnk.period), 32'(cur.period));
        chk("sb_link_ok",    32'(lnk.link_ok),      32'(cur.link));
        chk("sb_edge_cnt",   32'(lnk.edge_cnt),     32'(cur.edg));
        chk("sb_rise_width", 32'(lnk.rise_pulse),   32'd0);
        armed = 1'b0;
      end
      if (lnk.rise_pulse) begin
        chk("sb_rise_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("sb_rise_cycle", 32'(cyc), 32'(cur.cyc));
          armed = 1'b1;
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        chk("sb_rise_missing", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    int e_cyc;
    int pv0;
    int r;
    int gap;

    // Reset with the pair idle low
    set_pad(1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_low(200);
    @(posedge clk);
    #1;
    chk_all_zero("after_idle");

    // Single step: level at k+6, strobe only at k+7, no period update
    @(negedge clk);
    k = cyc;
    set_pad(1'b1);
    model_rise(k);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("step_level", 32'(lnk.rx_level),     32'(cyc >= k + 6));
      chk("step_rise",  32'(lnk.rise_pulse),   32'(cyc == k + 7));
      chk("step_pv",    32'(lnk.period_valid), 32'd0);
    end
    idle_low(20);

    // Short glitches are swallowed by the filter
    for (int len = 1; len <= 3; len++) begin
      for (int c = 0; c < len + 10; c++) begin
        @(negedge clk);
        set_pad(c < len);
        @(posedge clk);
        #1;
        chk("glitch_level", 32'(lnk.rx_level), 32'd0);
      end
    end
    idle_low(150);

    // Square wave of period 40: lock after the fourth rise
    pv0 = pv_total;
    repeat (4) pad_period(20, 20);
    chk("sq_pv_count", 32'(pv_total - pv0), 32'd3);
    chk("sq_period",   32'(lnk.period),     32'd40);
    chk("sq_link_ok",  32'(lnk.link_ok),    32'd1);
    chk("sq_edge_cnt", 32'(lnk.edge_cnt),   32'd0);
    repeat (2) pad_period(20, 20);
    chk("sq_edge_cnt2", 32'(lnk.edge_cnt),  32'd2);

    // Short gap of 8 drops lock, three valid periods relock
    pad_period(4, 4);
    pad_period(20, 20);
    chk("short_period",  32'(lnk.period),  32'd8);
    chk("short_link_ok", 32'(lnk.link_ok), 32'd0);
    repeat (2) pad_period(20, 20);
    chk("relock_pending", 32'(lnk.link_ok), 32'd0);
    pad_period(20, 20);
    chk("relock_link_ok", 32'(lnk.link_ok), 32'd1);

    // Frozen line: lock held through gap 100, lost one edge later
    e_cyc = m_last + LAT;
    do begin
      @(posedge clk);
      #1;
    end while (cyc < e_cyc + TMO);
    chk("tmo_hold_link_ok", 32'(lnk.link_ok), 32'd1);
    @(posedge clk);
    #1;
    chk("tmo_drop_link_ok",  32'(lnk.link_ok),  32'd0);
    chk("tmo_drop_edge_cnt", 32'(lnk.edge_cnt), 32'd0);
    chk("tmo_period_held",   32'(lnk.period),   32'd40);

    // Rise at gap exactly 100 keeps lock; gap 101 loses it
    repeat (4) pad_period(20, 20);
    pad_period(50, 50);
    pad_period(20, 20);
    chk("gap100_period",  32'(lnk.period),  32'd100);
    chk("gap100_link_ok", 32'(lnk.link_ok), 32'd1);
    pad_period(51, 50);
    pad_period(20, 20);
    chk("gap101_link_ok", 32'(lnk.link_ok), 32'd0);
    chk("gap101_period",  32'(lnk.period),  32'd40);

    // Asynchronous reset while locked
    repeat (4) pad_period(20, 20);
    chk("pre_rst_link_ok", 32'(lnk.link_ok), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_low(10);

    // Random gaps around the period and timeout boundaries
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      if (r < 3)       gap = $urandom_range(8, 11);
      else if (r == 3) gap = $urandom_range(96, 104);
      else             gap = $urandom_range(12, 60);
      pad_period(gap / 2, gap - gap / 2);
    end
    idle_low(20);
    chk("rise_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
